lsu_rmw: RTL and testbench

//  CPU-side load/store initiator driving the word-wide data memory port (we/addr/wd/rd).

---
 rtl/lsu_pkg.sv | 20 ++
 rtl/lsu_lane_merge.sv | 35 +++
 rtl/lsu_rmw.sv | 129 ++++++++++++
 tb/tb_lsu_rmw.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared funct3 codes, FSM state type and offset width for the load/store unit
package lsu_pkg;

    localparam int OFF_W = 2;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        RMW_RD,
        WRITE,
        ERR
    } lsu_state_t;

endpackage

// File: rtl/lsu_lane_merge.sv
// rtl/lsu_lane_merge.sv - combinational load lane extract/extend and store lane merge
module lsu_lane_merge
    import lsu_pkg::*;
(
    input  logic [2:0]       funct3,
    input  logic [OFF_W-1:0] off,
    input  logic [31:0]      rd_word,
    input  logic [31:0]      wdata,
    output logic [31:0]      load_data,
    output logic [31:0]      merge_data
);

    logic [31:0] shifted;

    always_comb begin
        shifted = rd_word >> {off, 3'b000};
        load_data = shifted;
        case (funct3)
            F3_B:    load_data = {{24{shifted[7]}}, shifted[7:0]};
            F3_BU:   load_data = {24'h000000, shifted[7:0]};
            F3_H:    load_data = {{16{shifted[15]}}, shifted[15:0]};
            F3_HU:   load_data = {16'h0000, shifted[15:0]};
            default: load_data = rd_word;
        endcase

        // off is already aligned to the access size by the caller
        merge_data = rd_word;
        case (funct3)
            F3_B:    merge_data[{off, 3'b000} +: 8]        = wdata[7:0];
            F3_H:    merge_data[{off[1], 4'b0000} +: 16]   = wdata[15:0];
            default: merge_data = wdata;
        endcase
    end

endmodule

// File: rtl/lsu_rmw.sv
// rtl/lsu_rmw.sv - RV32I load/store unit with read-modify-write sub-word stores; LSU_MISALIGN_TRAP_EN enables misalignment errors
module lsu_rmw
    import lsu_pkg::*;
#(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        req_funct3,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_err,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wd,
    input  logic [DATA_W-1:0] mem_rd
);

`ifdef LSU_MISALIGN_TRAP_EN
    localparam bit TRAP_EN = 1'b1;
`else
    localparam bit TRAP_EN = 1'b0;
`endif

    lsu_state_t state, next_state;

    logic [2:0]        r_f3;
    logic [OFF_W-1:0]  r_off;
    logic [DATA_W-1:0] r_wdata;

    logic              accept;
    logic              illegal;
    logic              misaligned;
    logic              bad;
    logic [OFF_W-1:0]  eff_off;
    logic [DATA_W-1:0] load_data;
    logic [DATA_W-1:0] merge_data;

    lsu_lane_merge u_lane_merge (
        .funct3     (r_f3),
        .off        (r_off),
        .rd_word    (mem_rd),
        .wdata      (r_wdata),
        .load_data  (load_data),
        .merge_data (merge_data)
    );

    // Request classification; without trapping, eff_off aligns the access down
    always_comb begin
        illegal    = req_we ? (req_funct3 > F3_W)
                            : (req_funct3 == 3'b011 || req_funct3 == 3'b110 || req_funct3 == 3'b111);
        misaligned = 1'b0;
        eff_off    = req_addr[OFF_W-1:0];
        case (req_funct3[1:0])
            2'b01: begin
                misaligned = req_addr[0];
                eff_off    = {req_addr[1], 1'b0};
            end
            2'b10: begin
                misaligned = |req_addr[OFF_W-1:0];
                eff_off    = '0;
            end
            default: ;
        endcase
        bad = illegal || (TRAP_EN && misaligned);
    end

    always_comb begin
        next_state = state;
        req_ready  = (state == IDLE);
        mem_we     = (state == WRITE);
        accept     = req_valid && (state == IDLE);
        case (state)
            IDLE: begin
                if (req_valid) begin
                    if (bad)                        next_state = ERR;
                    else if (!req_we)               next_state = LOAD;
                    else if (req_funct3[1:0] == 2'b10) next_state = WRITE;
                    else                            next_state = RMW_RD;
                end
            end
            LOAD:    next_state = IDLE;
            RMW_RD:  next_state = WRITE;
            WRITE:   next_state = IDLE;
            ERR:     next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            r_f3       <= '0;
            r_off      <= '0;
            r_wdata    <= '0;
            mem_addr   <= '0;
            mem_wd     <= '0;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
        end else begin
            state      <= next_state;
            resp_valid <= (state == LOAD) || (state == WRITE) || (state == ERR);
            resp_err   <= (state == ERR);
            resp_rdata <= (state == LOAD) ? load_data : '0;
            if (accept) begin
                r_f3    <= req_funct3;
                r_off   <= eff_off;
                r_wdata <= req_wdata;
                if (!bad) begin
                    mem_addr <= {req_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
                    if (req_we && req_funct3[1:0] == 2'b10) begin
                        mem_wd <= req_wdata;
                    end
                end
            end
            if (state == RMW_RD) begin
                mem_wd <= merge_data;
            end
        end
    end

endmodule

// File: tb/tb_lsu_rmw.sv
// tb/tb_lsu_rmw.sv - scoreboard bench for lsu_rmw against a byte-level memory reference model
module tb_lsu_rmw;

`ifdef LSU_MISALIGN_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, req_ready, req_we;
    logic [2:0]  req_funct3;
    logic [15:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid, resp_err, mem_we;
    logic [31:0] resp_rdata, mem_wd, mem_rd;
    logic [15:0] mem_addr;

    logic        poke_en = 1'b0;
    logic [13:0] poke_addr;
    logic [31:0] poke_data;
    logic [31:0] env_mem [0:16383];
    logic [7:0]  refb [0:255];

    typedef struct { logic [31:0] rdata; logic err; int lat; int start; } exp_t;
    typedef struct { logic [15:0] addr; logic [31:0] data; } wr_t;
    exp_t sq[$];
    wr_t  wq[$];

    int cycle = 0;
    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    lsu_rmw dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wd     (mem_wd),
        .mem_rd     (mem_rd)
    );

    assign mem_rd = env_mem[mem_addr[15:2]];

    always @(posedge clk) begin
        cycle <= cycle + 1;
        if (poke_en) env_mem[poke_addr] <= poke_data;
        else if (mem_we) env_mem[mem_addr[15:2]] <= mem_wd;
    end

    function automatic logic [31:0] ref_word(input logic [15:0] a);
        logic [7:0] b;
        b = {a[7:2], 2'b00};
        return {refb[b + 8'd3], refb[b + 8'd2], refb[b + 8'd1], refb[b]};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s act=%h exp=%h", name, act, exp);
        end
    endtask

    // Monitor: pops expected responses and writes whenever the DUT presents them
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (mem_we) begin
                if (wq.size() == 0) chk("unexpected_write", {16'h0, mem_addr}, 32'hFFFFFFFF);
                else begin
                    wr_t w;
                    w = wq.pop_front();
                    chk("write_addr", {16'h0, mem_addr}, {16'h0, w.addr});
                    chk("write_data", mem_wd, w.data);
                end
            end
            if (resp_valid) begin
                if (sq.size() == 0) chk("unexpected_resp", resp_rdata, 32'hFFFFFFFF);
                else begin
                    exp_t e;
                    e = sq.pop_front();
                    chk("resp_rdata", resp_rdata, e.rdata);
                    chk("resp_err", {31'h0, resp_err}, {31'h0, e.err});
                    chk("resp_latency", cycle - e.start, e.lat);
                end
            end
        end
    end

    task automatic poke_word(input logic [15:0] a, input logic [31:0] v);
        @(negedge clk);
        poke_en   = 1'b1;
        poke_addr = a[15:2];
        poke_data = v;
        for (int i = 0; i < 4; i++) refb[8'({a[7:2], 2'b00} + i)] = v[8*i +: 8];
        @(negedge clk);
        poke_en = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((sq.size() != 0 || wq.size() != 0) && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) chk("drain_timeout", 32'(n), 32'd0);
    endtask

    task automatic issue(input bit we, input logic [2:0] f3, input logic [15:0] a,
                         input logic [31:0] wd, input int gap);
        exp_t e;
        wr_t w;
        int n, size;
        bit ill, mis;
        logic [15:0] ea;
        logic [31:0] v;
        @(negedge clk);
        req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = a; req_wdata = wd;
        n = 0;
        while (!req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) begin
            chk("ready_timeout", 32'(n), 32'd0);
            req_valid = 1'b0;
            return;
        end
        ill  = we ? (f3 > 3'd2) : (f3 == 3'd3 || f3 >= 3'd6);
        size = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
        mis  = (size == 2 && a[0]) || (size == 4 && a[1:0] != 2'b00);
        e.start = cycle;
        if (ill || (TRAP && mis)) begin
            e.rdata = 0; e.err = 1'b1; e.lat = 2;
        end else begin
            ea = a & ~16'(size - 1);
            e.err = 1'b0;
            if (!we) begin
                v = 0;
                for (int i = 0; i < size; i++) v |= 32'(refb[8'(ea + 16'(i))]) << (8 * i);
                if (!f3[2] && size < 4 && v[8*size-1]) v |= ~((32'd1 << (8 * size)) - 1);
                e.rdata = v; e.lat = 2;
            end else begin
                for (int i = 0; i < size; i++) refb[8'(ea + 16'(i))] = wd[8*i +: 8];
                w.addr = {ea[15:2], 2'b00};
                w.data = ref_word(w.addr);
                wq.push_back(w);
                e.rdata = 0; e.lat = (size == 4) ? 2 : 3;
            end
        end
        sq.push_back(e);
        @(posedge clk);
        if (gap > 0) begin
            @(negedge clk);
            req_valid = 1'b0;
            repeat (gap - 1) @(negedge clk);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_req_ready"}, {31'h0, req_ready}, 32'd1);
        chk({tag, "_resp_valid"}, {31'h0, resp_valid}, 32'd0);
        chk({tag, "_resp_rdata"}, resp_rdata, 32'd0);
        chk({tag, "_resp_err"}, {31'h0, resp_err}, 32'd0);
        chk({tag, "_mem_we"}, {31'h0, mem_we}, 32'd0);
        chk({tag, "_mem_addr"}, {16'h0, mem_addr}, 32'd0);
        chk({tag, "_mem_wd"}, mem_wd, 32'd0);
    endtask

    initial begin
        rst_n = 1'b0;
        req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'd0; req_addr = 16'd0; req_wdata = 32'd0;
        for (int i = 0; i < 64; i++) poke_word(16'(i * 4), $urandom);
        @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1'b1;

        poke_word(16'h0010, 32'hDEADBEEF);
        issue(1'b0, 3'b010, 16'h0010, 32'h0, 2);
        drain();
        poke_word(16'h0010, 32'h80FF7F01);
        issue(1'b0, 3'b000, 16'h0013, 32'h0, 1);
        issue(1'b0, 3'b100, 16'h0013, 32'h0, 1);
        issue(1'b0, 3'b101, 16'h0012, 32'h0, 1);
        drain();
        poke_word(16'h0020, 32'h11223344);
        issue(1'b1, 3'b000, 16'h0021, 32'h000000AB, 2);
        drain();
        chk("sb_mem_word", env_mem[16'h0020 >> 2], 32'h1122AB44);
        issue(1'b1, 3'b001, 16'h0003, 32'h0000BEEF, 2);
        drain();
        chk("sh_0003_mem_word", env_mem[0], ref_word(16'h0000));
        issue(1'b1, 3'b010, 16'h0030, 32'h12345678, 0);
        issue(1'b0, 3'b010, 16'h0030, 32'h0, 2);
        drain();

        // Reset asserted while an SB sits in RMW_RD
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b000; req_addr = 16'h0044; req_wdata = 32'h5A;
        @(negedge clk);
        req_valid = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check_reset_outputs("midrmw");
        chk("midrmw_mem_word", env_mem[16'h0044 >> 2], ref_word(16'h0044));
        rst_n = 1'b1;

        for (int k = 0; k < 300; k++) begin
            issue(1'($urandom % 2), 3'($urandom % 8), 16'($urandom % 256), $urandom, int'($urandom % 3));
        end
        drain();
        for (int i = 0; i < 64; i++) chk("final_mem", env_mem[i], ref_word(16'(i * 4)));
        chk("queues_empty", 32'(sq.size() + wq.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout act=%0d exp=finish", cycle);
        $fatal(1);
    end

endmodule
